bitonic_stream_ctrl: RTL and testbench

Streaming sequencer around the combinational 8×32 ascending sorter `bitonic`. Collects a list of 1–8 unsigned 32-bit words from a valid/ready input stream, presents them to the sorter, holds for a settle window, and captures the result. It then replays the sorted words on a valid/ready output stream with a last marker. It is the block that lets the sorter sit on a bus-side stream path instead of being driven by hand.

---
 rtl/bitonic_pkg.sv | 20 ++
 rtl/bitonic.sv | 39 +++
 rtl/bitonic_stream_ctrl.sv | 108 ++++++++++
 tb/tb_bitonic_stream_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_pkg.sv
// Shared types and constants for the bitonic sorter and its stream sequencer.
// The list geometry is fixed by the combinational sorting network.
package bitonic_pkg;

    localparam int DATA_W   = 32;
    localparam int LIST_LEN = 8;

    typedef logic [DATA_W-1:0]                word_t;
    typedef logic [LIST_LEN-1:0][DATA_W-1:0] list_t;

    // All-ones padding sorts behind every genuine word.
    localparam word_t PAD_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

endpackage

// File: rtl/bitonic.sv
// Combinational 8x32 ascending bitonic sorting network.
// Every stage is a layer of compare-exchange elements.
module bitonic
    import bitonic_pkg::*;
(
    input  list_t original_list_i,
    output list_t sorted_list_o
);

    always_comb begin
        list_t net;
        word_t lo;
        word_t hi;
        // NOTE: every temporary gets a value up front so no path through the block can infer a latch.
        net = original_list_i;
        lo  = '0;
        hi  = '0;
        for (int k = 2; k <= LIST_LEN; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                for (int i = 0; i < LIST_LEN; i++) begin
                    if ((i ^ j) > i) begin
                        lo = (net[3'(i)] < net[3'(i ^ j)]) ? net[3'(i)] : net[3'(i ^ j)];
                        hi = (net[3'(i)] < net[3'(i ^ j)]) ? net[3'(i ^ j)] : net[3'(i)];
                        // Direction alternates per k-block so each merge sees a bitonic sequence.
                        if ((i & k) == 0) begin
                            net[3'(i)]     = lo;
                            net[3'(i ^ j)] = hi;
                        end else begin
                            net[3'(i)]     = hi;
                            net[3'(i ^ j)] = lo;
                        end
                    end
                end
            end
        end
        sorted_list_o = net;
    end

endmodule

// File: rtl/bitonic_stream_ctrl.sv
// Valid/ready sequencer around the bitonic sorter: collect a list of 1..8 words,
// let the sorter settle for SORT_WAIT cycles, then replay the sorted words with a last marker.
module bitonic_stream_ctrl #(
    parameter int DATA_W    = 32,
    parameter int LIST_LEN  = 8,
    parameter int SORT_WAIT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o
);
    import bitonic_pkg::*;

    if (DATA_W != bitonic_pkg::DATA_W || LIST_LEN != bitonic_pkg::LIST_LEN) begin : g_bad_geometry
        $error("bitonic_stream_ctrl: DATA_W and LIST_LEN are fixed by the sorter");
    end
    if (SORT_WAIT < 1 || SORT_WAIT > 15) begin : g_bad_sort_wait
        $error("bitonic_stream_ctrl: SORT_WAIT must be 1..15");
    end

    localparam logic [3:0] SORT_LAST = 4'(SORT_WAIT - 1);

    state_t     state;
    logic [3:0] wr_cnt;
    logic [3:0] rd_ptr;
    logic [3:0] len;
    logic [3:0] wait_cnt;
    list_t      in_buf;
    list_t      out_buf;
    list_t      sorted_list;
    logic       list_done;
    logic       drain_done;

    // in_buf is held stable through SORT; that is the multicycle path into out_buf.
    bitonic u_bitonic (
        .original_list_i (in_buf),
        .sorted_list_o   (sorted_list)
    );

    assign list_done  = s_last_i || (wr_cnt == 4'd7);
    assign drain_done = (rd_ptr == len - 4'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= LOAD;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            len      <= '0;
            wait_cnt <= '0;
            // NOTE: the list buffers are cleared on reset so no stale words survive into a later list.
            in_buf   <= '0;
            out_buf  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid_i) begin
                        in_buf[wr_cnt[2:0]] <= s_data_i;
                        wr_cnt              <= wr_cnt + 4'd1;
                        if (list_done) begin
                            for (int i = 0; i < LIST_LEN; i++) begin
                                if (4'(i) > wr_cnt) in_buf[3'(i)] <= PAD_VALUE;
                            end
                            len      <= wr_cnt + 4'd1;
                            wait_cnt <= '0;
                            state    <= SORT;
                        end
                    end
                end
                SORT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == SORT_LAST) begin
                        out_buf <= sorted_list;
                        rd_ptr  <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready_i) begin
                        if (drain_done) begin
                            wr_cnt <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + 4'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Outputs depend on registered state only; no input reaches an output combinationally.
    assign s_ready_o = (state == LOAD);
    assign m_valid_o = (state == DRAIN);
    assign busy_o    = (state != LOAD);
    assign m_data_o  = m_valid_o ? out_buf[rd_ptr[2:0]] : '0;
    assign m_last_o  = m_valid_o && drain_done;

endmodule

// File: tb/tb_bitonic_stream_ctrl.sv
// Bench for bitonic_stream_ctrl: a default instance (SORT_WAIT=1) for directed lists and a
// SORT_WAIT=3 instance for random lists under random backpressure, both checked every cycle.
module tb_bitonic_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       s_valid, s_last, s_ready, m_valid, m_last, busy, m_ready;
    logic [1:0][31:0] s_data, m_data;
    logic             m_ready0, rnd_on, rnd_r;

    assign m_ready = {rnd_on ? rnd_r : 1'b1, m_ready0};

    bitonic_stream_ctrl u_dut_w1 (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]), .s_last_i(s_last[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_data_o(m_data[0]), .m_last_o(m_last[0]),
        .busy_o(busy[0])
    );

    bitonic_stream_ctrl #(.SORT_WAIT(3)) u_dut_w3 (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]), .s_last_i(s_last[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_data_o(m_data[1]), .m_last_o(m_last[1]),
        .busy_o(busy[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: words being collected, and the sorted list still owed downstream.
    logic [31:0] ld [2][8];
    logic [31:0] ex [2][8];
    int          ld_n [2];
    int          ex_n [2];
    int          ex_h [2];
    int          rdy_at [2];
    int          close_at [2];
    logic [31:0] cap [2][32];
    bit          cap_l [2][32];
    int          cap_n [2];
    int          gap [2];
    int          lat [2];
    int          busy_cnt [2];
    bit          pv_stall [2];
    bit          pv_valid [2];
    logic [31:0] pv_data [2];

    function automatic int sw(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int u);
        bit          bm;
        bit          vm;
        logic [31:0] t;
        string       p;
        p  = $sformatf("u%0d ", u);
        bm = (ex_h[u] < ex_n[u]);
        vm = bm && (cyc >= rdy_at[u]);
        check({p, "busy_o"}, busy[u], bm);
        check({p, "s_ready_o"}, s_ready[u], !bm);
        check({p, "m_valid_o"}, m_valid[u], vm);
        check({p, "m_data_o"}, m_data[u], vm ? ex[u][ex_h[u]] : 32'd0);
        check({p, "m_last_o"}, m_last[u], vm && (ex_h[u] == ex_n[u] - 1));
        if (pv_stall[u] && m_valid[u]) check({p, "stall_data"}, m_data[u], pv_data[u]);

        if (busy[u] && !m_valid[u]) gap[u]++;
        if (m_valid[u] && !pv_valid[u]) begin
            check({p, "sort_gap"}, gap[u], sw(u));
            lat[u] = cyc - close_at[u] + 1;
        end
        if (m_valid[u] && m_ready[u] && cap_n[u] < 32) begin
            cap[u][cap_n[u]]   = m_data[u];
            cap_l[u][cap_n[u]] = m_last[u];
            cap_n[u]++;
        end
        if (busy[u]) busy_cnt[u]++;
        pv_stall[u] = m_valid[u] && !m_ready[u];
        pv_valid[u] = m_valid[u];
        pv_data[u]  = m_data[u];

        // Advance the model across the coming edge.
        if (rst) begin
            ld_n[u] = 0;
            ex_n[u] = 0;
            ex_h[u] = 0;
        end else if (vm && m_ready[u]) begin
            ex_h[u]++;
            if (ex_h[u] == ex_n[u]) begin
                ex_h[u] = 0;
                ex_n[u] = 0;
            end
        end else if (!bm && s_valid[u]) begin
            ld[u][ld_n[u]] = s_data[u];
            ld_n[u]++;
            if (s_last[u] || ld_n[u] == 8) begin
                for (int i = 0; i < ld_n[u]; i++) ex[u][i] = ld[u][i];
                for (int a = 1; a < ld_n[u]; a++) begin
                    for (int b = a; b > 0 && ex[u][b-1] > ex[u][b]; b--) begin
                        t            = ex[u][b];
                        ex[u][b]     = ex[u][b-1];
                        ex[u][b-1]   = t;
                    end
                end
                ex_n[u]     = ld_n[u];
                ex_h[u]     = 0;
                ld_n[u]     = 0;
                rdy_at[u]   = cyc + 1 + sw(u);
                close_at[u] = cyc + 1;
                gap[u]      = 0;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_r <= 1'($urandom_range(0, 1));

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int u = 0; u < 2; u++) step(u);
        end
    end

    task automatic send(input int u, input logic [31:0] d, input bit last);
        bit hs;
        s_valid[u] = 1'b1;
        s_data[u]  = d;
        s_last[u]  = last;
        hs = 1'b0;
        for (int t = 0; t < 1000 && !hs; t++) begin
            @(negedge clk);
            hs = s_ready[u];
            @(posedge clk);
            #1;
        end
        check($sformatf("u%0d send accepted", u), hs, 1'b1);
        s_valid[u] = 1'b0;
        s_last[u]  = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int t;
        t = 0;
        while ((ex_n[u] != 0 || ld_n[u] != 0) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check($sformatf("u%0d drained", u), ex_n[u] + ld_n[u], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_list(input int u, input string nm, input int n,
                              input logic [31:0] e [16], input logic [15:0] lm);
        check({nm, " count"}, cap_n[u], n);
        for (int i = 0; i < n && i < cap_n[u]; i++) begin
            check($sformatf("%s word %0d", nm, i), cap[u][i], e[i]);
            check($sformatf("%s last %0d", nm, i), cap_l[u][i], lm[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v [16];
        logic [31:0] e [16];
        int          n;
        bit          last;
        logic [31:0] d;
        int          t;

        rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready0 = 1'b0; rnd_on = 1'b0; rnd_r = 1'b1;
        for (int u = 0; u < 2; u++) begin
            ld_n[u] = 0; ex_n[u] = 0; ex_h[u] = 0; rdy_at[u] = 0; close_at[u] = 0; cap_n[u] = 0;
            gap[u] = 0; lat[u] = 0; busy_cnt[u] = 0; pv_stall[u] = 0; pv_valid[u] = 0; pv_data[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset s_ready_o", s_ready, 2'b11);
        check("reset m_valid_o", m_valid, 2'b00);
        check("reset m_data_o", m_data, 64'd0);
        check("reset m_last_o", m_last, 2'b00);
        check("reset busy_o", busy, 2'b00);
        rst = 1'b0;

        // Full eight-word list.
        m_ready0 = 1'b1;
        cap_n[0] = 0;
        v = '{7, 3, 9, 1, 8, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) send(0, v[i], i == 7);
        wait_idle(0);
        e = '{0, 1, 2, 3, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0};
        check_list(0, "full", 8, e, 16'h0080);
        check("full latency", lat[0], 2);

        // Short list containing a genuine all-ones word.
        cap_n[0] = 0;
        send(0, 32'd5, 1'b0);
        send(0, 32'hFFFF_FFFF, 1'b0);
        send(0, 32'd1, 1'b1);
        wait_idle(0);
        e = '{1, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_list(0, "short", 3, e, 16'h0004);

        // Nine words without last: the list closes at eight, the ninth opens the next list.
        cap_n[0] = 0;
        for (int i = 0; i < 9; i++) send(0, 32'(8 - i), 1'b0);
        send(0, 32'd4, 1'b1);
        wait_idle(0);
        e = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 4, 0, 0, 0, 0, 0, 0};
        check_list(0, "overflow", 10, e, 16'h0280);

        // Reset after the second output handshake.
        cap_n[0] = 0;
        m_ready0 = 1'b0;
        send(0, 32'd30, 1'b0);
        send(0, 32'd10, 1'b0);
        send(0, 32'd20, 1'b1);
        t = 0;
        while (!m_valid[0] && t < 100) begin @(posedge clk); #1; t++; end
        m_ready0 = 1'b1;
        t = 0;
        while (cap_n[0] < 2 && t < 100) begin @(posedge clk); #1; t++; end
        m_ready0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset m_valid_o", m_valid[0], 1'b0);
        check("post-reset s_ready_o", s_ready[0], 1'b1);
        rst = 1'b0;
        e = '{10, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_list(0, "pre-reset", 2, e, 16'h0000);
        cap_n[0] = 0;
        m_ready0 = 1'b1;
        send(0, 32'd2, 1'b0);
        send(0, 32'd1, 1'b1);
        wait_idle(0);
        e = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_list(0, "after-reset", 2, e, 16'h0002);

        // Single-word list.
        cap_n[0] = 0;
        busy_cnt[0] = 0;
        send(0, 32'd42, 1'b1);
        wait_idle(0);
        e = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_list(0, "single", 1, e, 16'h0001);
        check("single busy cycles", busy_cnt[0], 2);

        // Random lists on the SORT_WAIT=3 instance under random backpressure.
        rnd_on = 1'b1;
        for (int l = 0; l < 12; l++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                case ($urandom % 4)
                    0:       d = 32'hFFFF_FFFF;
                    1:       d = $urandom;
                    default: d = $urandom_range(0, 15);
                endcase
                last = (i == n - 1) && (n < 8 || ($urandom % 2) == 0);
                send(1, d, last);
                if ($urandom % 4 == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle(1);
        rnd_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
